ahb_slave_mem_model: RTL and testbench
======================================

# ahb_slave_mem_model

Parametrised AHB-Lite slave memory model for simulation benches, the next generation of the fixed 32-bit BFM slave. It adds configurable data width and depth, runtime-programmable wait states, HSIZE byte-lane writes, two-cycle ERROR responses for illegal accesses, and a completed-transfer counter. It sits on a bus fabric slave port beside the UART and bridge under test.

## Interface
- AWIDTH, 12, HADDR width in bits.
- DWIDTH, 32, data bus width; legal values are 32 and 64.
- DEPTH, 1024, memory depth in DWIDTH-bit words; must satisfy DEPTH*DWIDTH/8 <= 2^AWIDTH.
- INIT_WAITS, 0, wait-state value used when WAITS_EN=0 (range 0..15).

Ports:
- HCLK  in  1  bus clock; all logic runs on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HWRITE  in  1  1 = write, 0 = read.
- HADDR  in  AWIDTH  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  accepted but ignored.
- HWDATA  in  DWIDTH  write data, valid during the data phase.
- HREADYIN  in  1  bus-wide ready.
- WAITS_EN  in  1  1 = use WAITS, 0 = use INIT_WAITS.
- WAITS  in  4  wait states per transfer, sampled at the address phase.
- HRDATA  out  DWIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- XFERCNT  out  16  count of OKAY-completed transfers; wraps at 0xFFFF -> 0.

## Operation
- An address phase is accepted when HSEL & HREADYIN & HTRANS[1] at a rising HCLK edge. On acceptance the block registers HADDR, HWRITE, HSIZE and the wait count (WAITS or INIT_WAITS).
- IDLE and BUSY transfers, and unselected cycles, get a zero-wait OKAY response with no state change.
- An access is illegal if any of the following holds:
  - HSIZE > log2(DWIDTH/8);
  - HADDR is not aligned to 2^HSIZE;
  - word index HADDR >> log2(DWIDTH/8) >= DEPTH.
- State machine:
  - IDLE: on a legal accept with wait count 0 -> DATA; with wait count > 0 -> WAIT; on an illegal accept -> ERR1.
  - WAIT: decrement the wait counter; when it reaches 1 -> DATA.
  - DATA: complete the transfer. A new accept in this cycle re-enters as from IDLE; otherwise -> IDLE.
  - ERR1 -> ERR2 unconditionally. ERR2 then behaves as DATA for a new accept.
- Writes: lane = HADDR[log2(DWIDTH/8)-1:0], little-endian. Only the 2^HSIZE selected bytes of the addressed word are written from HWDATA, committed at the edge that ends DATA. Illegal writes modify nothing.
- Reads: HRDATA = mem[word index] during DATA of a read, combinational from the registered address. HRDATA = 0 in all other cycles.
- A read immediately following a write to the same address returns the new data.
- Memory is zero at time 0 and is not cleared by HRESET.
- XFERCNT increments by 1 at the end of every OKAY DATA cycle where HTRANS was NONSEQ or SEQ. It does not count IDLE/BUSY or ERROR transfers.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, XFERCNT=0, state IDLE, wait counter 0.
- Reset asserted mid-transfer aborts immediately: no write occurs and the outputs take their reset values.
- Latency with N wait states: HREADYOUT is low for N cycles after the address phase, then high for one DATA cycle. Zero waits gives a single-cycle data phase.
- Wait-state cycles: HRESP=0 and HRDATA=0.
- ERROR response: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1. Wait states are skipped for errors.
- Pipelining: an accept in DATA or ERR2 starts the next transfer with no bubble. Accepts while HREADYOUT=0 cannot occur because HREADYIN is low.
- WAITS changes take effect only at the next address phase.

## Test plan
- Word write then read, DWIDTH=32, waits 0: write 0xDEADBEEF to 0x010, then read 0x010 -> HRDATA=0xDEADBEEF in the cycle after the read address phase, HREADYOUT=1 throughout, XFERCNT=2.
- Byte lanes: write 0xDEADBEEF to 0x020, then byte write 0xAA (on HWDATA[23:16]) to 0x022, then read 0x020 -> 0xDEAABEEF.
- Wait states: WAITS_EN=1, WAITS=3, read -> HREADYOUT low for exactly 3 cycles then high for 1 with valid data. Changing WAITS to 0 mid-transfer does not shorten that transfer.
- Errors: halfword write to 0x001, then word read at DEPTH*4 -> each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles; memory unchanged; XFERCNT unchanged.
- Back-to-back write then read of the same address 0x040 with zero waits -> the read returns the written data with no bubble.
- Reset: assert HRESET in WAIT of a write -> HREADYOUT=1, HRESP=0, XFERCNT=0; a subsequent read returns the old data. Also preload XFERCNT to 0xFFFF via transfers, then one more transfer -> 0.

Source files
------------

// File: rtl/ahb_slave_mem_model_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mem_model_if
// Brief    : AHB-Lite slave bus bundle with wait-state control and counter.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_slave_mem_model_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
);
    logic              HSEL;
    logic              HWRITE;
    logic [AWIDTH-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DWIDTH-1:0] HWDATA;
    logic              HREADYIN;
    logic              WAITS_EN;
    logic [3:0]        WAITS;
    logic [DWIDTH-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [15:0]       XFERCNT;

    modport master (
        output HSEL, HWRITE, HADDR, HTRANS, HSIZE, HBURST, HWDATA,
               HREADYIN, WAITS_EN, WAITS,
        input  HRDATA, HREADYOUT, HRESP, XFERCNT
    );

    modport slave (
        input  HSEL, HWRITE, HADDR, HTRANS, HSIZE, HBURST, HWDATA,
               HREADYIN, WAITS_EN, WAITS,
        output HRDATA, HREADYOUT, HRESP, XFERCNT
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_mem_model
// Brief    : AHB-Lite slave memory with programmable waits, byte lanes, ERROR.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_mem_model #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 1024,
    parameter int INIT_WAITS = 0
) (
    input  wire                   HCLK,
    input  wire                   HRESET,
    ahb_slave_mem_model_if.slave  bus
);
    localparam int c_NBYTES    = DWIDTH / 8;
    localparam int c_LANE_BITS = $clog2(c_NBYTES);
    localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_wait_cnt;
    logic                   r_ready;
    logic                   r_resp;
    logic [15:0]            r_xfercnt;
    logic                   r_write;
    logic [c_LANE_BITS-1:0] r_lane;
    logic [2:0]             r_size;
    logic [c_IDX_W-1:0]     r_idx;

    // Zero at time 0 and deliberately outside the reset domain
    logic [DWIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic              w_accept;
    logic              w_illegal;
    logic [3:0]        w_waits;
    logic [AWIDTH-1:0] w_word_full;
    logic [31:0]       w_align_mask;
    logic [c_NBYTES-1:0] w_byte_en;
    logic              w_unused_ok;

    assign w_unused_ok  = ^{bus.HBURST, bus.HTRANS[0]};
    assign w_accept     = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
    assign w_waits      = bus.WAITS_EN ? bus.WAITS : 4'(INIT_WAITS);
    assign w_word_full  = bus.HADDR >> c_LANE_BITS;
    assign w_align_mask = (32'd1 << bus.HSIZE) - 32'd1;
    assign w_illegal    = (32'(bus.HSIZE) > 32'(c_LANE_BITS))
                       || ((32'(bus.HADDR) & w_align_mask) != 32'd0)
                       || (32'(w_word_full) >= 32'(DEPTH));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_ready    <= 1'b1;
            r_resp     <= 1'b0;
            r_xfercnt  <= 16'd0;
            r_write    <= 1'b0;
            r_lane     <= '0;
            r_size     <= 3'd0;
            r_idx      <= '0;
        end else begin
            if (r_state == ST_DATA) begin
                r_xfercnt <= r_xfercnt + 16'd1;
            end
            case (r_state)
                ST_WAIT: begin
                    if (r_wait_cnt <= 4'd1) begin
                        r_state    <= ST_DATA;
                        r_wait_cnt <= 4'd0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                    r_ready <= 1'b1;
                    r_resp  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 can all take a new address phase
                    if (w_accept) begin
                        r_write <= bus.HWRITE;
                        r_lane  <= bus.HADDR[c_LANE_BITS-1:0];
                        r_size  <= bus.HSIZE;
                        r_idx   <= w_word_full[c_IDX_W-1:0];
                        if (w_illegal) begin
                            r_state <= ST_ERR1;
                            r_ready <= 1'b0;
                            r_resp  <= 1'b1;
                        end else if (w_waits == 4'd0) begin
                            r_state <= ST_DATA;
                            r_ready <= 1'b1;
                            r_resp  <= 1'b0;
                        end else begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= w_waits;
                            r_ready    <= 1'b0;
                            r_resp     <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_resp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_byte_en = '0;
        for (int b = 0; b < c_NBYTES; b++) begin
            if ((b >= int'(r_lane)) && (b < int'(r_lane) + (1 << r_size))) begin
                w_byte_en[b] = 1'b1;
            end
        end
    end

    // Async reset clears r_state first, so a reset mid-transfer never writes
    always_ff @(posedge HCLK) begin
        if (!HRESET && (r_state == ST_DATA) && r_write) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (w_byte_en[b]) begin
                    r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_idx] : '0;
    assign bus.HREADYOUT = r_ready;
    assign bus.HRESP     = r_resp;
    assign bus.XFERCNT   = r_xfercnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_mem_model
// Brief    : Directed bench for ahb_slave_mem_model (32-bit, 256 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem_model;
    localparam int c_AW    = 12;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ahb_slave_mem_model_if #(.AWIDTH(c_AW), .DWIDTH(c_DW)) bus ();
    assign bus.HREADYIN = bus.HREADYOUT;

    ahb_slave_mem_model #(
        .AWIDTH(c_AW), .DWIDTH(c_DW), .DEPTH(c_DEPTH), .INIT_WAITS(0)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
        bus.HSIZE  = 3'd2;
        bus.HBURST = 3'd0;
    endtask

    task automatic addr_phase(input logic wr, input logic [11:0] addr, input logic [2:0] size);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'd2;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer has ended
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input bit clr_waits,
                        output logic [31:0] rdata, output int lows,
                        output logic resp_low, output logic [31:0] rd_low,
                        output logic resp_hi);
        addr_phase(wr, addr, size);
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = wdata;
        if (clr_waits) bus.WAITS = 4'd0;
        lows     = 0;
        resp_low = 1'b0;
        rd_low   = '0;
        while (bus.HREADYOUT == 1'b0 && lows < 20) begin
            resp_low = resp_low | bus.HRESP;
            rd_low   = rd_low | bus.HRDATA;
            lows++;
            @(posedge clk); #1;
        end
        if (lows >= 20) chk("ready_timeout", 64'(lows), 64'd0);
        rdata   = bus.HRDATA;
        resp_hi = bus.HRESP;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, rdl;
    int          lo;
    logic        rsl, rsh;

    initial begin
        rst          = 1'b1;
        bus_idle();
        bus.HWDATA   = '0;
        bus.WAITS_EN = 1'b0;
        bus.WAITS    = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_resp",  64'(bus.HRESP),     64'd0);
        chk("rst_rdata", 64'(bus.HRDATA),    64'd0);
        chk("rst_cnt",   64'(bus.XFERCNT),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word write then read
        xfer(1'b1, 12'h010, 3'd2, 32'hDEADBEEF, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("wr_lows", 64'(lo), 64'd0);
        chk("wr_resp", 64'(rsh), 64'd0);
        xfer(1'b0, 12'h010, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("rd_lows", 64'(lo), 64'd0);
        chk("rd_data", 64'(rd), 64'hDEADBEEF);
        chk("cnt_2",   64'(bus.XFERCNT), 64'd2);

        // Byte lane write
        xfer(1'b1, 12'h020, 3'd2, 32'hDEADBEEF, 1'b0, rd, lo, rsl, rdl, rsh);
        xfer(1'b1, 12'h022, 3'd0, 32'h00AA0000, 1'b0, rd, lo, rsl, rdl, rsh);
        xfer(1'b0, 12'h020, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("byte_data", 64'(rd), 64'hDEAABEEF);
        chk("cnt_5",     64'(bus.XFERCNT), 64'd5);

        // Three wait states; WAITS cleared after the address phase
        bus.WAITS_EN = 1'b1;
        bus.WAITS    = 4'd3;
        xfer(1'b0, 12'h010, 3'd2, 32'h0, 1'b1, rd, lo, rsl, rdl, rsh);
        chk("wait_lows",  64'(lo),  64'd3);
        chk("wait_resp",  64'(rsl), 64'd0);
        chk("wait_rdata", 64'(rdl), 64'd0);
        chk("wait_data",  64'(rd),  64'hDEADBEEF);
        chk("cnt_6",      64'(bus.XFERCNT), 64'd6);
        bus.WAITS_EN = 1'b0;

        // Illegal accesses
        xfer(1'b1, 12'h001, 3'd1, 32'hFFFFFFFF, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("err1_lows", 64'(lo),  64'd1);
        chk("err1_rlo",  64'(rsl), 64'd1);
        chk("err1_rhi",  64'(rsh), 64'd1);
        xfer(1'b0, 12'h400, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("err2_lows",  64'(lo),  64'd1);
        chk("err2_rlo",   64'(rsl), 64'd1);
        chk("err2_rhi",   64'(rsh), 64'd1);
        chk("err2_rdata", 64'(rd),  64'd0);
        chk("err_cnt",    64'(bus.XFERCNT), 64'd6);
        xfer(1'b0, 12'h000, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("err_nomod", 64'(rd), 64'd0);

        // Back-to-back write then read of 0x040
        addr_phase(1'b1, 12'h040, 3'd2);
        @(posedge clk); #1;
        bus.HWDATA = 32'h12345678;
        addr_phase(1'b0, 12'h040, 3'd2);
        chk("b2b_wr_ready", 64'(bus.HREADYOUT), 64'd1);
        @(posedge clk); #1;
        bus_idle();
        chk("b2b_rd_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("b2b_rd_data",  64'(bus.HRDATA),    64'h12345678);
        @(posedge clk); #1;
        chk("cnt_9", 64'(bus.XFERCNT), 64'd9);

        // Reset while a write is in its wait states
        bus.WAITS_EN = 1'b1;
        bus.WAITS    = 4'd2;
        addr_phase(1'b1, 12'h010, 3'd2);
        @(posedge clk); #1;
        bus_idle();
        bus.HWDATA = 32'h55555555;
        chk("mid_wait_ready", 64'(bus.HREADYOUT), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("mid_rst_resp",  64'(bus.HRESP),     64'd0);
        chk("mid_rst_cnt",   64'(bus.XFERCNT),   64'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.WAITS_EN = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 12'h010, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("post_rst_data", 64'(rd), 64'hDEADBEEF);
        chk("cnt_1",         64'(bus.XFERCNT), 64'd1);

        // Stream 65534 pipelined reads to reach 0xFFFF, then wrap
        addr_phase(1'b0, 12'h010, 3'd2);
        repeat (65534) @(posedge clk);
        #1;
        bus_idle();
        @(posedge clk); #1;
        chk("cnt_ffff", 64'(bus.XFERCNT), 64'hFFFF);
        xfer(1'b0, 12'h010, 3'd2, 32'h0, 1'b0, rd, lo, rsl, rdl, rsh);
        chk("cnt_wrap", 64'(bus.XFERCNT), 64'd0);
        chk("wrap_data", 64'(rd), 64'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
